// File: rtl/outbuf_addrprocess.sv
// outbuf_addrprocess: circular write/read address generation, fill level and flow flags for the DAC output RAM
module outbuf_addrprocess #(
  parameter int ADDR_BITS   = 10,
  parameter int START_LEVEL = 512
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 FirWe,
  input  logic                 DacTick,
  input  logic                 ClrFlags,
  output logic                 OutBufwea,
  output logic [ADDR_BITS-1:0] OutBufAddra,
  output logic                 OutBufenb,
  output logic [ADDR_BITS-1:0] OutBufAddrb,
  output logic                 DacValid,
  output logic [ADDR_BITS:0]   Level,
  output logic                 Running,
  output logic                 Overflow,
  output logic                 Underflow
);
  typedef enum logic {PREFILL, RUN} state_t;
  state_t               state;
  logic [ADDR_BITS-1:0] wptr, rptr;
  logic [ADDR_BITS:0]   level_nxt;
  logic                 full, empty, wr_ok, rd_ok, ovf_ev, udf_ev;
  assign full      = Level == (ADDR_BITS+1)'(2**ADDR_BITS);
  assign empty     = Level == '0;
  assign wr_ok     = FirWe && !full;
  assign rd_ok     = DacTick && state == RUN && !empty;
  assign ovf_ev    = FirWe && full;
  assign udf_ev    = DacTick && state == RUN && empty;
  // simultaneous accepted read and write cancel, keeping Level steady
  assign level_nxt = Level + (ADDR_BITS+1)'(wr_ok) - (ADDR_BITS+1)'(rd_ok);
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state       <= PREFILL;
      wptr        <= '0;
      rptr        <= '0;
      OutBufwea   <= 1'b0;
      OutBufAddra <= '0;
      OutBufenb   <= 1'b0;
      OutBufAddrb <= '0;
      DacValid    <= 1'b0;
      Level       <= '0;
      Running     <= 1'b0;
      Overflow    <= 1'b0;
      Underflow   <= 1'b0;
    end else begin
      OutBufwea <= wr_ok;
      OutBufenb <= rd_ok;
      DacValid  <= OutBufenb;
      Level     <= level_nxt;
      Overflow  <= ovf_ev || (Overflow && !ClrFlags);
      Underflow <= udf_ev || (Underflow && !ClrFlags);
      if (wr_ok) begin
        OutBufAddra <= wptr;
        wptr        <= wptr + ADDR_BITS'(1);
      end
      if (rd_ok) begin
        OutBufAddrb <= rptr;
        rptr        <= rptr + ADDR_BITS'(1);
      end
      case (state)
        PREFILL: if (level_nxt >= (ADDR_BITS+1)'(START_LEVEL)) begin
          state   <= RUN;
          Running <= 1'b1;
        end
        RUN: if (udf_ev) begin
          state   <= PREFILL;
          Running <= 1'b0;
        end
        default: begin
          state   <= PREFILL;
          Running <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_outbuf_addrprocess.sv
// tb_outbuf_addrprocess: directed scoreboard bench for the output-buffer address processor
module tb_outbuf_addrprocess;
  localparam int AB = 4;
  localparam int SL = 8;
  localparam int DEPTH = 16;
  logic sys_clk = 0, reset = 0, FirWe = 0, DacTick = 0, ClrFlags = 0;
  logic OutBufwea, OutBufenb, DacValid, Running, Overflow, Underflow;
  logic [AB-1:0] OutBufAddra, OutBufAddrb;
  logic [AB:0] Level;
  int checks = 0, failures = 0;
  int wq[$], rq[$];
  int m_wp, m_rp, m_lvl;
  bit m_run, m_ovf, m_udf, prev_enb;

  outbuf_addrprocess #(.ADDR_BITS(AB), .START_LEVEL(SL)) dut (
    .sys_clk(sys_clk), .reset(reset), .FirWe(FirWe), .DacTick(DacTick), .ClrFlags(ClrFlags),
    .OutBufwea(OutBufwea), .OutBufAddra(OutBufAddra), .OutBufenb(OutBufenb), .OutBufAddrb(OutBufAddrb),
    .DacValid(DacValid), .Level(Level), .Running(Running), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops expected addresses whenever the DUT strobes an enable
  always @(negedge sys_clk) begin
    if (!reset) prev_enb = 0;
    else begin
      if (OutBufwea) begin
        if (wq.size() == 0) chk("unexpected_wea", 1, 0);
        else chk("wr_addr", 32'(OutBufAddra), wq.pop_front());
      end
      if (OutBufenb) begin
        if (rq.size() == 0) chk("unexpected_enb", 1, 0);
        else chk("rd_addr", 32'(OutBufAddrb), rq.pop_front());
      end
      if (DacValid || prev_enb) chk("dac_valid", 32'(DacValid), 32'(prev_enb));
      prev_enb = OutBufenb;
    end
  end

  task automatic cyc(input bit we, input bit tk, input bit clr);
    bit acc_w, acc_r, ev_o, ev_u;
    acc_w = we && m_lvl != DEPTH;
    acc_r = tk && m_run && m_lvl != 0;
    ev_o  = we && m_lvl == DEPTH;
    ev_u  = tk && m_run && m_lvl == 0;
    if (acc_w) begin wq.push_back(m_wp); m_wp = (m_wp + 1) % DEPTH; end
    if (acc_r) begin rq.push_back(m_rp); m_rp = (m_rp + 1) % DEPTH; end
    m_ovf = ev_o || (m_ovf && !clr);
    m_udf = ev_u || (m_udf && !clr);
    m_lvl = m_lvl + int'(acc_w) - int'(acc_r);
    if (ev_u) m_run = 0;
    else if (!m_run && m_lvl >= SL) m_run = 1;
    FirWe = we; DacTick = tk; ClrFlags = clr;
    @(posedge sys_clk); #1;
    FirWe = 0; DacTick = 0; ClrFlags = 0;
    chk("status", 32'({Level, Running, Overflow, Underflow}), 32'({5'(m_lvl), m_run, m_ovf, m_udf}));
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    chk("reset_outs", 32'({OutBufwea, OutBufAddra, OutBufenb, OutBufAddrb, DacValid, Level, Running, Overflow, Underflow}), 0);
    wq.delete(); rq.delete();
    m_wp = 0; m_rp = 0; m_lvl = 0; m_run = 0; m_ovf = 0; m_udf = 0;
    @(posedge sys_clk); #1;
    reset = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    repeat (7) cyc(1, 0, 0);
    chk("p1_level", 32'(Level), 7);
    chk("p1_running", 32'(Running), 0);
    cyc(0, 1, 0);
    chk("p1_flags", 32'({Overflow, Underflow}), 0);
    cyc(1, 0, 0);
    chk("p2_running", 32'(Running), 1);
    cyc(0, 1, 0);
    chk("p2_enb", 32'(OutBufenb), 1);
    chk("p2_addrb", 32'(OutBufAddrb), 0);
    chk("p2_level", 32'(Level), 7);
    cyc(0, 0, 0);
    chk("p2_valid", 32'(DacValid), 1);
    do_reset();
    repeat (17) cyc(1, 0, 0);
    chk("p3_level", 32'(Level), 16);
    chk("p3_ovf", 32'(Overflow), 1);
    chk("p3_drop", 32'(OutBufwea), 0);
    cyc(1, 0, 1);
    chk("p3_set_wins", 32'(Overflow), 1);
    cyc(0, 0, 1);
    chk("p3_clr", 32'(Overflow), 0);
    cyc(1, 1, 0);
    chk("full_rw_level", 32'(Level), 15);
    chk("full_rw_ovf", 32'(Overflow), 1);
    chk("full_rw_wea", 32'(OutBufwea), 0);
    cyc(0, 0, 1);
    repeat (40) cyc(1, 1, 0);
    chk("p4_level", 32'(Level), 15);
    chk("p4_addra", 32'(OutBufAddra), 7);
    chk("p4_addrb", 32'(OutBufAddrb), 8);
    repeat (14) cyc(0, 1, 0);
    chk("p5_level", 32'(Level), 1);
    cyc(0, 1, 0);
    chk("p5_k", 32'(OutBufAddrb), 7);
    cyc(0, 1, 0);
    chk("p5_udf", 32'(Underflow), 1);
    chk("p5_running", 32'(Running), 0);
    chk("p5_no_enb", 32'(OutBufenb), 0);
    repeat (8) cyc(1, 0, 0);
    chk("p5_rerun", 32'(Running), 1);
    cyc(0, 1, 0);
    chk("p5_resume", 32'(OutBufAddrb), 8);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("p6_level", 32'(Level), 5);
    chk("p6_enb", 32'(OutBufenb), 1);
    do_reset();
    cyc(1, 0, 0);
    chk("p6_addra", 32'(OutBufAddra), 0);
    repeat (3) cyc(0, 0, 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/outbuf_addrprocess.md
Name: outbuf_addrprocess

Overview:
- Output-buffer address and flow controller for the resampling FIR datapath; the read-out counterpart of the input-buffer address processor.
- Accepts FIR result write strobes and generates circular write addresses into the dual-port output RAM.
- Drains the RAM at the output sample rate (DacTick) through circular read addresses.
- Provides prefill gating, fill level, and sticky overflow/underflow flags to the DAC interface.

Parameters:
ADDR_BITS, 10, RAM address width; depth = 2^ADDR_BITS entries
START_LEVEL, 512, fill level at which read-out starts or restarts (1..2^ADDR_BITS)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
FirWe  input  1  one-cycle strobe: FIR output sample ready for storage
DacTick  input  1  one-cycle strobe: DAC requests next output sample
ClrFlags  input  1  synchronous clear of Overflow/Underflow
OutBufwea  output  1  RAM port-A write enable
OutBufAddra  output  ADDR_BITS  RAM port-A write address
OutBufenb  output  1  RAM port-B read enable
OutBufAddrb  output  ADDR_BITS  RAM port-B read address
DacValid  output  1  RAM port-B data valid for the DAC
Level  output  ADDR_BITS+1  current fill count, 0..2^ADDR_BITS
Running  output  1  high in RUN state
Overflow  output  1  sticky: write dropped because buffer full
Underflow  output  1  sticky: DacTick with buffer empty while running

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - Write pointer and read pointer 0, Level 0, state PREFILL.
  - Reset mid-operation discards buffer contents; any in-flight OutBufwea/OutBufenb/DacValid drop immediately.
- Derived conditions: full = (Level == 2^ADDR_BITS); empty = (Level == 0).
- Write side:
  - FirWe at cycle n with !full is an accepted write.
  - Accepted write: OutBufwea=1 at n+1 with OutBufAddra = write pointer value at n. The pointer then increments modulo 2^ADDR_BITS, wrapping 2^ADDR_BITS-1 -> 0.
  - FirWe while full: no OutBufwea, pointer unchanged, Overflow set at n+1.
- Read side:
  - DacTick at cycle n in RUN with !empty is an accepted read.
  - Accepted read: OutBufenb=1 at n+1 with OutBufAddrb = read pointer value at n. The pointer then increments with the same wrap rule.
  - DacValid=1 at n+2, matching 1-cycle RAM read latency.
  - DacTick outside RUN: ignored, no flag.
- OutBufAddra and OutBufAddrb hold their last value when the corresponding enable is low.
- Level update, registered at n+1:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted in the same cycle.
  - Full/empty decisions at cycle n use the Level value at n, so a simultaneous write at full with a read is still dropped.
- State machine:
  - PREFILL: Running=0. Move to RUN when the next-cycle Level >= START_LEVEL.
  - RUN: Running=1. A DacTick while empty sets Underflow and moves to PREFILL; the read pointer is unchanged.
  - No other transitions. Writes continue in both states.
- Flags:
  - Overflow and Underflow stay set until ClrFlags or reset.
  - ClrFlags in the same cycle as a new set event: the set wins.
- Pointer difference always equals Level modulo 2^ADDR_BITS; no gap addresses.

Test Plan:
(Bench uses ADDR_BITS=4, START_LEVEL=8.)
1. Reset release, 7 FirWe strobes -> OutBufAddra 0..6 with OutBufwea, Level=7, Running=0; DacTick ignored, no OutBufenb, no flags.
2. 8th FirWe -> Level=8, Running=1 next cycle; DacTick -> OutBufenb with OutBufAddrb=0 one cycle later, DacValid two cycles later, Level=7.
3. 17 FirWe with no reads from empty -> Level saturates at 16, write addresses 0..15, 17th write dropped, Overflow=1; ClrFlags -> Overflow=0.
4. Steady state with FirWe and DacTick in the same cycle repeatedly across 40 cycles -> Level constant, both addresses wrap 15->0 correctly.
5. RUN with Level=1, two DacTicks -> first read at addr k, second sets Underflow, Running=0; refill to 8 -> RUN resumes, reading from k+1.
6. reset asserted while OutBufenb is high and Level=5 -> all outputs 0 immediately; after release the first write goes to address 0.
